// File: rtl/sram_mport_arbiter_if.sv
// ============================================================================
// Module   : sram_mport_arbiter_if
// Brief    : Client req/ack bus plus SRAM pin bundle for sram_mport_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_mport_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int AW     = 19
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*8-1:0]  din;
  logic [NPORTS-1:0]    ack;
  logic [NPORTS*8-1:0]  dout;
  logic [AW-1:0]        sram_addr;
  logic [7:0]           sram_d_o;
  logic [7:0]           sram_d_i;
  logic                 sram_d_oe;
  logic                 sram_we_n;

  modport master (
    output req, we, addr, din, sram_d_i,
    input  ack, dout, sram_addr, sram_d_o, sram_d_oe, sram_we_n
  );

  modport slave (
    input  req, we, addr, din, sram_d_i,
    output ack, dout, sram_addr, sram_d_o, sram_d_oe, sram_we_n
  );
endinterface

`default_nettype wire

// File: rtl/sram_mport_arbiter.sv
// ============================================================================
// Module   : sram_mport_arbiter
// Brief    : Round-robin time-multiplexing of one async 8-bit SRAM among
//            NPORTS clients. Macro SRAM_VIDEO_PRIO_EN: port 0 fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_mport_arbiter #(
  parameter int NPORTS     = 4,
  parameter int AW         = 19,
  parameter int ACC_CYCLES = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  sram_mport_arbiter_if.slave bus
);
  localparam int            PW         = $clog2(NPORTS);
  localparam logic [PW-1:0] C_LAST     = PW'(NPORTS - 1);
  localparam logic [3:0]    C_CNT_LAST = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       gnt_q, gnt_d;
  logic                we_lat_q, we_lat_d;
  logic [AW-1:0]       sram_addr_q, sram_addr_d;
  logic [7:0]          sram_d_o_q, sram_d_o_d;
  logic                sram_d_oe_q, sram_d_oe_d;
  logic                sram_we_n_q, sram_we_n_d;
  logic [NPORTS-1:0]   ack_q, ack_d;
  logic [NPORTS*8-1:0] dout_q, dout_d;

  logic [PW-1:0]       win;
  logic                win_vld;

  // Scan from the rr pointer upwards, wrapping explicitly at NPORTS.
  always_comb begin : p_pick
    int            idx;
    logic [PW-1:0] idx_p;
    idx     = 0;
    idx_p   = '0;
    win     = '0;
    win_vld = 1'b0;
`ifdef SRAM_VIDEO_PRIO_EN
    if (bus.req[0]) win_vld = 1'b1;
`endif
    for (int i = 0; i < NPORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      idx_p = PW'(idx);
`ifdef SRAM_VIDEO_PRIO_EN
      if (!win_vld && (idx_p != '0) && bus.req[idx_p]) begin
`else
      if (!win_vld && bus.req[idx_p]) begin
`endif
        win     = idx_p;
        win_vld = 1'b1;
      end
    end
  end

  // Output registers are loaded with the values for the state being entered.
  always_comb begin : p_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    we_lat_d    = we_lat_q;
    sram_addr_d = sram_addr_q;
    sram_d_o_d  = sram_d_o_q;
    sram_d_oe_d = 1'b0;
    sram_we_n_d = 1'b1;
    ack_d       = '0;
    dout_d      = dout_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d       = win;
          we_lat_d    = bus.we[win];
          sram_addr_d = bus.addr[int'(win)*AW +: AW];
          if (bus.we[win]) sram_d_o_d = bus.din[int'(win)*8 +: 8];
          sram_d_oe_d = bus.we[win];
          state_d     = SETUP;
        end
      end
      SETUP: begin
        sram_d_oe_d = we_lat_q;
        sram_we_n_d = ~we_lat_q;
        cnt_d       = '0;
        state_d     = STROBE;
      end
      STROBE: begin
        sram_d_oe_d = we_lat_q;
        if (cnt_q == C_CNT_LAST) begin
          ack_d[gnt_q] = 1'b1;
          if (!we_lat_q) dout_d[int'(gnt_q)*8 +: 8] = bus.sram_d_i;
          state_d = HOLD;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          sram_we_n_d = ~we_lat_q;
        end
      end
      HOLD: begin
`ifdef SRAM_VIDEO_PRIO_EN
        if (gnt_q != '0) rr_d = (gnt_q == C_LAST) ? '0 : gnt_q + PW'(1);
`else
        rr_d = (gnt_q == C_LAST) ? '0 : gnt_q + PW'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      we_lat_q    <= 1'b0;
      sram_addr_q <= '0;
      sram_d_o_q  <= '0;
      sram_d_oe_q <= 1'b0;
      sram_we_n_q <= 1'b1;
      ack_q       <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      we_lat_q    <= we_lat_d;
      sram_addr_q <= sram_addr_d;
      sram_d_o_q  <= sram_d_o_d;
      sram_d_oe_q <= sram_d_oe_d;
      sram_we_n_q <= sram_we_n_d;
      ack_q       <= ack_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.dout      = dout_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_d_o  = sram_d_o_q;
  assign bus.sram_d_oe = sram_d_oe_q;
  assign bus.sram_we_n = sram_we_n_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mport_arbiter.sv
// ============================================================================
// Module   : tb_sram_mport_arbiter
// Brief    : Self-checking bench: transaction-level model plus directed cases.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_mport_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 19;
  localparam int ACC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  sram_mport_arbiter_if #(.NPORTS(NP), .AW(AW)) bus ();
  sram_mport_arbiter #(.NPORTS(NP), .AW(AW), .ACC_CYCLES(ACC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_mport_arbiter_if #(.NPORTS(3), .AW(AW)) bus3 ();
  sram_mport_arbiter #(.NPORTS(3), .AW(AW), .ACC_CYCLES(ACC)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );
  assign bus3.sram_d_i = 8'h00;

  // Asynchronous SRAM: 1K bytes, upper address bits alias.
  logic [7:0] sram_mem [0:1023];
  bit         mem_init_done = 1'b0;
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= 8'(i * 37 + 11);
      mem_init_done <= 1'b1;
    end else if (bus.sram_we_n === 1'b0) begin
      sram_mem[bus.sram_addr[9:0]] <= bus.sram_d_o;
    end
  end
  assign bus.sram_d_i = sram_mem[bus.sram_addr[9:0]];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0]    ref_mem [0:1023];
  logic [7:0]    exp_dout [NP];
  bit            m_busy;
  int            m_k;
  int            m_port;
  int            m_rr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din;

  function automatic int pick(logic [NP-1:0] r, int rr);
`ifdef SRAM_VIDEO_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < NP; i++) begin
      int j;
      j = (rr + i) % NP;
`ifdef SRAM_VIDEO_PRIO_EN
      if (j == 0) continue;
`endif
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0;
    m_k    = 0;
    m_rr   = 0;
    for (int p = 0; p < NP; p++) exp_dout[p] = 8'h00;
  endtask

  initial begin : p_model
    logic [NP-1:0] ea;
    int            w;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        m_reset();
        chk("rst_ack", 64'(bus.ack), 64'h0);
        chk("rst_oe", 64'(bus.sram_d_oe), 64'h0);
        chk("rst_we_n", 64'(bus.sram_we_n), 64'h1);
        chk("rst_addr", 64'(bus.sram_addr), 64'h0);
        chk("rst_d_o", 64'(bus.sram_d_o), 64'h0);
        chk("rst_dout", 64'(bus.dout), 64'h0);
        continue;
      end
      ea = '0;
      if (m_busy && m_k == ACC + 2) ea[m_port] = 1'b1;
      chk("ack", 64'(bus.ack), 64'(ea));
      chk("sram_d_oe", 64'(bus.sram_d_oe), 64'(m_busy && m_we));
      chk("sram_we_n", 64'(bus.sram_we_n),
          64'(!(m_busy && m_we && m_k >= 2 && m_k <= ACC + 1)));
      if (m_busy) begin
        chk("sram_addr", 64'(bus.sram_addr), 64'(m_addr));
        if (m_we) chk("sram_d_o", 64'(bus.sram_d_o), 64'(m_din));
      end
      for (int p = 0; p < NP; p++)
        chk($sformatf("dout%0d", p), 64'(bus.dout[p*8 +: 8]), 64'(exp_dout[p]));
      // advance to the next cycle
      if (m_busy) begin
        if (m_k == ACC + 1) begin
          if (m_we) ref_mem[m_addr[9:0]] = m_din;
          else      exp_dout[m_port] = ref_mem[m_addr[9:0]];
`ifdef SRAM_VIDEO_PRIO_EN
          if (m_port != 0) m_rr = (m_port + 1) % NP;
`else
          m_rr = (m_port + 1) % NP;
`endif
        end
        if (m_k == ACC + 2) m_busy = 1'b0;
        else                m_k++;
      end else begin
        w = pick(bus.req, m_rr);
        if (w >= 0) begin
          m_busy = 1'b1;
          m_k    = 1;
          m_port = w;
          m_we   = bus.we[w];
          m_addr = bus.addr[w*AW +: AW];
          m_din  = bus.din[w*8 +: 8];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(int p, bit r, bit w, logic [AW-1:0] a, logic [7:0] d);
    bus.req[p]          = r;
    bus.we[p]           = w;
    bus.addr[p*AW +: AW] = a;
    bus.din[p*8 +: 8]   = d;
  endtask

  task automatic wait_ack(int p, output int cyc, output int wel, output int oeh);
    cyc = 0;
    wel = 0;
    oeh = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.sram_we_n === 1'b0) wel++;
      if (bus.sram_d_oe === 1'b1) oeh++;
      if (bus.ack[p] === 1'b1) break;
      if (cyc >= 100) begin
        timeout_fail($sformatf("ack%0d_wait", p));
        break;
      end
    end
  endtask

  int got[$];
  task automatic collect(int n);
    int cyc;
    cyc = 0;
    while (n > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        chk("ack_onehot", 64'($onehot(bus.ack)), 64'h1);
        for (int p = 0; p < NP; p++) if (bus.ack[p]) got.push_back(p);
        n--;
      end
    end
    if (n > 0) timeout_fail("collect_acks");
  endtask

  task automatic wait_ack3(int p);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus3.ack != 3'b000) begin
        chk($sformatf("np3_grant_expect%0d", p), 64'(bus3.ack), 64'(3'b001 << p));
        break;
      end
      if (cyc >= 100) begin
        timeout_fail("np3_ack_wait");
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : p_main
    int cyc, wel, oeh, noack;
    int exp_ord [6];
    int gap [NP];
    bit pend [NP];
    logic [NP-1:0] ackv;
    logic [AW-1:0] ra;

    rst = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.din = '0;
    bus3.req = '0; bus3.we = '0; bus3.addr = '0; bus3.din = '0;
    repeat (2) @(negedge clk);
    chk("init_we_n", 64'(bus.sram_we_n), 64'h1);
    chk("init_ack", 64'(bus.ack), 64'h0);
    tick();
    rst = 1'b0;

    // reset in the middle of a write strobe
    tick();
    set_port(0, 1'b1, 1'b1, 19'h12345, 8'h3C);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.sram_we_n !== 1'b0 && cyc < 50);
    if (cyc >= 50) timeout_fail("strobe_wait");
    chk("strobe_addr", 64'(bus.sram_addr), 64'h12345);
    #2;
    rst = 1'b1;
    bus.req[0] = 1'b0;
    #1;
    chk("async_we_n", 64'(bus.sram_we_n), 64'h1);
    chk("async_oe", 64'(bus.sram_d_oe), 64'h0);
    chk("async_ack", 64'(bus.ack), 64'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    noack = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack != '0) noack++;
    end
    chk("no_ack_after_reset", 64'(noack), 64'h0);

    // all ports requesting from reset: strict rotation
    tick();
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, p[0], AW'(p + 1), 8'(8'h40 + p));
    got.delete();
    collect(6);
    tick();
    bus.req = '0;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), 64'((i < got.size()) ? got[i] : -1), 64'(exp_ord[i]));

    // ports 0 and 3 continuously, fresh rr pointer
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, AW'(5), 8'h00);
    set_port(3, 1'b1, 1'b0, AW'(6), 8'h00);
    got.delete();
    collect(3);
    tick();
    bus.req[0] = 1'b0;
    collect(1);
    tick();
    bus.req[3] = 1'b0;
`ifdef SRAM_VIDEO_PRIO_EN
    exp_ord = '{0, 0, 0, 3, 0, 0};
`else
    exp_ord = '{0, 3, 0, 3, 0, 0};
`endif
    for (int i = 0; i < 4; i++)
      chk($sformatf("prio_order%0d", i), 64'((i < got.size()) ? got[i] : -1), 64'(exp_ord[i]));

    // port 1 write 0xA5 to 0x00100
    set_port(1, 1'b1, 1'b1, 19'h00100, 8'hA5);
    wait_ack(1, cyc, wel, oeh);
    chk("wr_latency", 64'(cyc), 64'(3 + ACC));
    chk("wr_we_n_low_cycles", 64'(wel), 64'(ACC));
    tick();
    bus.req[1] = 1'b0;

    // port 2 reads it back
    set_port(2, 1'b1, 1'b0, 19'h00100, 8'h00);
    wait_ack(2, cyc, wel, oeh);
    chk("rd_latency", 64'(cyc), 64'(3 + ACC));
    chk("rd_dout_at_ack", 64'(bus.dout[2*8 +: 8]), 64'hA5);
    chk("rd_oe_cycles", 64'(oeh), 64'h0);
    tick();
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_dout_held", 64'(bus.dout[2*8 +: 8]), 64'hA5);

    // 3-port instance: wrap from rr=2 back to port 0
    tick();
    bus3.req[1] = 1'b1;
    wait_ack3(1);
    tick();
    bus3.req = 3'b101;
    wait_ack3(2);
    tick();
    bus3.req[2] = 1'b0;
    wait_ack3(0);
    tick();
    bus3.req = 3'b000;

    // randomized traffic
    for (int p = 0; p < NP; p++) begin
      gap[p]  = $urandom_range(0, 3);
      pend[p] = 1'b0;
    end
    repeat (3000) begin
      @(negedge clk);
      ackv = bus.ack;
      tick();
      for (int p = 0; p < NP; p++) begin
        ra       = AW'($urandom);
        ra[9:0]  = 10'($urandom_range(0, 15));
        if (pend[p] && ackv[p]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_port(p, 1'b1, 1'($urandom), ra, 8'($urandom));
          end else begin
            pend[p]    = 1'b0;
            bus.req[p] = 1'b0;
            gap[p]     = $urandom_range(0, 4);
          end
        end else if (!pend[p]) begin
          if (gap[p] == 0) begin
            set_port(p, 1'b1, 1'($urandom), ra, 8'($urandom));
            pend[p] = 1'b1;
          end else begin
            gap[p]--;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sram_mport_arbiter.md
Name: sram_mport_arbiter

Overview:
Parametrised successor to the two-port SRAM controller. It time-multiplexes one asynchronous 8-bit SRAM among NPORTS requesters (ULA video fetch, CPU, DivMMC/loader, ...) using a per-port req/ack handshake. Arbitration is round-robin, and the strobe width is programmable. It sits between the core's memory clients and the external SRAM pins. Tristate of the data bus is resolved at top level.

Parameters:
NPORTS, 4, number of client ports (2..8)
AW, 19, SRAM address width
ACC_CYCLES, 2, clk cycles of we_n low / read settle (1..15)

Ports:
clk  in  1  28 MHz system clock
rst  in  1  asynchronous, active-high reset
req  in  NPORTS  per-port access request, level
we  in  NPORTS  per-port write (1) / read (0), valid while req
addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW]
din  in  NPORTS*8  per-port write data
ack  out  NPORTS  one-cycle completion pulse per port
dout  out  NPORTS*8  per-port read data, held until that port's next read completes
sram_addr  out  AW  SRAM address
sram_d_o  out  8  data to SRAM
sram_d_i  in  8  data from SRAM
sram_d_oe  out  1  1 = drive sram_d_o onto bus
sram_we_n  out  1  SRAM write strobe, active low

Behaviour:
- Reset values: ack=0, dout=0, sram_addr=0, sram_d_o=0, sram_d_oe=0, sram_we_n=1, FSM=IDLE, rr pointer=0, strobe counter=0.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any req, grant the lowest-index requesting port at or after rr pointer, wrapping modulo NPORTS. Latch addr/we/din of the granted port into internal registers. Go to SETUP. If no req, stay in IDLE.
- SETUP (1 cycle): sram_addr=latched addr. Write: sram_d_oe=1, sram_d_o=latched din, sram_we_n=1. Read: sram_d_oe=0. Go to STROBE.
- STROBE (ACC_CYCLES cycles, counter 0..ACC_CYCLES-1): write: sram_we_n=0. Read: on the last STROBE cycle, sample sram_d_i into dout of the granted port. Go to HOLD.
- HOLD (1 cycle): sram_we_n=1, address and data still held (write hold time). Pulse ack[granted]=1. rr pointer = granted+1 (mod NPORTS). Go to IDLE.
- Transaction latency: req seen in IDLE -> ack at cycle 3+ACC_CYCLES after grant decision. dout is valid in the same cycle as ack.
- Handshake: client holds req/we/addr/din stable until ack. Inputs are latched at grant, so changes after grant are ignored. Client drops req the cycle after ack. If req is still high in the IDLE cycle after ack, the arbiter treats it as a new request, subject to round-robin.
- Fairness: with all ports continuously requesting, grants follow order 0,1,..,NPORTS-1,0,... No port waits more than NPORTS-1 transactions.
- Simultaneous requests: only the round-robin winner is served; others stay pending and are not acked.
- sram_we_n never goes low while sram_addr changes. sram_d_oe is 0 for the entire read.
- Mid-operation reset: all outputs return to reset values immediately, asynchronously. The in-flight access is abandoned and no ack is issued.
- Width rule: rr pointer and grant index are $clog2(NPORTS) bits. The wrap from NPORTS-1 goes to 0 explicitly, including for non-power-of-2 NPORTS.

Optional Feature:
SRAM_VIDEO_PRIO_EN: when defined, port 0 is fixed top priority. In IDLE, req[0] always wins regardless of rr pointer, and a port-0 grant does not advance rr pointer. The remaining ports arbitrate round-robin among themselves. When not defined, all ports are pure round-robin as above.

Test Plan:
- Reset mid-STROBE of a write to 0x12345 -> sram_we_n=1, sram_d_oe=0, ack=0 asynchronously. After release, FSM is IDLE and no ack occurs.
- Port 1 write 0xA5 to 0x00100, ACC_CYCLES=2 -> sram_we_n low for exactly 2 cycles with addr/data stable 1 cycle either side. ack[1] pulses 5 cycles after grant.
- Port 2 read of 0x00100 with SRAM model returning 0xA5 -> dout[2]=0xA5 coincident with ack[2]. sram_d_oe=0 throughout. dout[2] is held after req drops.
- All 4 ports requesting continuously from reset -> grant order 0,1,2,3,0,1. Each ack is a single cycle.
- NPORTS=3, ports 2 and 0 requesting, rr=2 -> port 2 served, then port 0 (wrap correct).
- With SRAM_VIDEO_PRIO_EN, ports 0 and 3 requesting continuously -> 0,0,... until port 0 drops req, then 3. Without the macro -> 0,3,0,3.
